full_adder_nb: RTL and testbench

//   Parameterised N-bit binary adder with carry-in and carry-out, built as a

---
 rtl/full_adder_nb_pkg.sv | 14 +
 rtl/full_adder_nb_fa1b.sv | 20 ++
 rtl/full_adder_nb.sv | 45 ++++
 tb/tb_full_adder_nb.sv | 128 ++++++++++++
 4 files changed

// File: rtl/full_adder_nb_pkg.sv
// Shared arithmetic constants and a reference carry helper for the adder slice.
// Latency: none (declarations only).
// Backpressure: none.
package full_adder_nb_pkg;

    // Default operand width for clocked adders in this slice
    localparam int ARITH_DEFAULT_WIDTH = 16;

    // Single-bit carry generate/propagate, shared so every carry cell reads the same
    function automatic logic carry_out_1b(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

endpackage

// File: rtl/full_adder_nb_fa1b.sv
// One-bit full adder cell, chained into a ripple carry by the N-bit top.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_1b
    import full_adder_nb_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of one bit position
    always_comb begin
        s    = a ^ b ^ cin;
        cout = carry_out_1b(a, b, cin);
    end

endmodule

// File: rtl/full_adder_nb.sv
// N-bit ripple-carry adder with carry-in; {cout,s} = a + b + cin, registered.
// Latency: 1 cycle, a new result every cycle; async active-low reset clears outputs.
// Backpressure: none, no handshake and no enable.
module full_adder_nb
    import full_adder_nb_pkg::*;
#(
    parameter int N = ARITH_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    // Carry chain: c[0] is the carry-in, c[N] is the carry out of the top bit
    logic [N:0]   c;
    logic [N-1:0] sum;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder_1b u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    // Capture the combinational result; reset drops any pending result immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum;
            cout <= c[N];
        end
    end

endmodule

// File: tb/tb_full_adder_nb.sv
// Self-checking bench for full_adder_nb at N=16 with a result scoreboard.
// Latency: expects each result one cycle after the applying edge.
// Backpressure: none.
module tb_full_adder_nb;

    localparam int N = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s;
    logic         cout;

    int checks;
    int failures;

    logic [N:0] exp_q[$];

    full_adder_nb #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got {cout,s}=%h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operand set at the falling edge, queue its expected result,
    // then compare the oldest queued result just after the next rising edge.
    task automatic apply(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tc, input logic [N:0] texp);
        logic [N:0] e;
        @(negedge clk);
        a   = ta;
        b   = tb;
        cin = tc;
        exp_q.push_back(texp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, {cout, s}, {(N+1){1'bx}});
        end else begin
            e = exp_q.pop_front();
            chk(tag, {cout, s}, e);
        end
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;
        checks   = 0;
        failures = 0;
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b0;
        rst_n    = 1'b1;

        // Reset asserted before any clock edge clears outputs
        #1 rst_n = 1'b0;
        #1 chk("reset_async_initial", {cout, s}, 17'h0);

        // Outputs stay cleared while reset is held and the clock toggles
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk("reset_held", {cout, s}, 17'h0);
        end

        @(negedge clk);
        rst_n = 1'b1;

        apply("add_3_5",        16'h0003, 16'h0005, 1'b0, 17'h00008);
        apply("add_3_5_cin",    16'h0003, 16'h0005, 1'b1, 17'h00009);
        apply("ripple_ffff_1",  16'hFFFF, 16'h0000, 1'b1, 17'h10000);

        // Reset mid-cycle clears a nonzero result without a clock edge
        #2 rst_n = 1'b0;
        #1 chk("reset_midcycle", {cout, s}, 17'h0);
        exp_q.delete();
        @(posedge clk);
        #1 chk("reset_mid_held", {cout, s}, 17'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("ones_ones_cin",  16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
        apply("msb_msb",        16'h8000, 16'h8000, 1'b0, 17'h10000);

        // Back-to-back on consecutive edges
        apply("b2b_0",          16'h0001, 16'h0002, 1'b0, 17'h00003);
        apply("b2b_1",          16'h1234, 16'h4321, 1'b1, 17'h05556);
        apply("b2b_2",          16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF);

        // Random operands against a 17-bit golden sum, with sporadic resets
        for (int i = 0; i < 10000; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            apply("random", ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc});
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1 chk("random_reset", {cout, s}, 17'h0);
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        chk("queue_drained", 17'(exp_q.size()), 17'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
